alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state changes on the rising edge of clk except reset.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  instruction-valid strobe; sampled only in IDLE.
REQ-005 inst  input  32  RV32I instruction word; sampled with start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse on completion (WB state).
REQ-008 illegal  output  1  one-cycle pulse when a sampled instruction is not a supported ALU instruction.
REQ-009 rs1_addr, rs2_addr, rd_addr  output  5 each  register-file addresses: inst[19:15], inst[24:20], inst[11:7].
REQ-010 OP  output  4  ALU operation code.
REQ-011 rs2_imm_s  output  1  1 = second operand is imm, 0 = rs2.
REQ-012 imm  output  32  decoded immediate.
REQ-013 ld_RR  output  1  one-cycle load enable for the operand registers A/B.
REQ-014 ld_F  output  1  one-cycle load enable for the result and flag registers.
REQ-015 rf_we  output  1  one-cycle register-file write enable for F into rd.
REQ-016 retired  output  32  count of completed instructions.

Function
REQ-017 The FSM SHALL have states IDLE, DECODE, READ, EXEC, WB.
- IDLE->DECODE on start=1; inst latched into an internal instruction register.
- DECODE->READ if legal, else DECODE->IDLE with illegal=1.
- READ->EXEC->WB->IDLE unconditionally.
REQ-018 start SHALL be ignored while busy=1; the latched instruction SHALL NOT change until the next return to IDLE.
REQ-019 Strobes SHALL be exactly one cycle each: ld_RR in READ, ld_F in EXEC, rf_we and done in WB.
REQ-020 Start-to-done latency SHALL be 4 cycles: start sampled at edge N, done high during cycle N+4. The next start is accepted at edge N+5.
REQ-021 Addresses, OP, rs2_imm_s and imm SHALL be decoded from the latched instruction and remain stable from DECODE through WB.
REQ-022 Legal opcodes SHALL be 0110011 (R-type, rs2_imm_s=0) and 0010011 (I-type, rs2_imm_s=1); all other opcodes are illegal.
REQ-023 OP SHALL be derived from funct3 as follows:
- 000: add=0000; R-type with funct7=0100000 is sub=1000.
- 001: sll=0001.
- 010: slt=0010.
- 011: sltu=0011.
- 100: xor=0100.
- 101: srl=0101; funct7=0100000 is sra=1101.
- 110: or=0110.
- 111: and=0111.
REQ-024 funct7 legality:
- R-type: funct7 SHALL be 0000000, or 0100000 only with funct3 000/101.
- I-type with funct3 001/101: funct7 SHALL be 0000000, or 0100000 only with funct3 101.
- I-type with other funct3 values: funct7 is ignored.
- Any other combination is illegal.
REQ-025 imm SHALL be:
- I-type shifts: {27'b0, inst[24:20]}.
- Other I-type: inst[31:20] sign-extended to 32 bits.
- R-type: 0.
REQ-026 rf_we SHALL be suppressed when rd_addr=0; done still pulses.
REQ-027 retired SHALL increment by 1 in WB, wrap from FFFF_FFFF to 0, and not count illegal instructions.
REQ-028 An illegal instruction SHALL produce no ld_RR, ld_F, rf_we or done pulse.

Reset
REQ-029 On rst=1 the FSM SHALL enter IDLE immediately, regardless of the current state.
REQ-030 During and after reset the following SHALL be 0: busy, done, illegal, ld_RR, ld_F, rf_we, retired, the instruction register, and all decoded outputs.
REQ-031 Reset mid-instruction SHALL abort it with no further strobes, and SHALL NOT increment retired.

Verification
REQ-032 add x3,x1,x2 (0x002081B3) with start -> one cycle each of ld_RR, ld_F, then rf_we+done; OP=0000, rs2_imm_s=0, rd_addr=3; retired=1.
REQ-033 addi x5,x0,-1 (0xFFF00293) -> OP=0000, rs2_imm_s=1, imm=FFFF_FFFF, rd_addr=5.
REQ-034 srai x1,x1,3 (0x4030D093) -> OP=1101, imm=0000_0003; sub (0x40208133) -> OP=1000.
REQ-035 Opcode 0000011 -> illegal pulse in DECODE, back in IDLE after 2 cycles, no strobes, retired unchanged.
REQ-036 rst asserted in EXEC -> busy=0 immediately, no rf_we, retired unchanged; start held high during busy -> ignored.
REQ-037 add with rd=x0 (0x00208033) -> done=1, rf_we=0.

Source files
------------

// File: rtl/alu_ctrl.sv
// RV32I ALU-instruction controller: latches an instruction word, decodes it and
// sequences operand load, execute and register writeback strobes.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inst,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [3:0]  OP,
  output logic        rs2_imm_s,
  output logic [31:0] imm,
  output logic        ld_RR,
  output logic        ld_F,
  output logic        rf_we,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_r;
  logic        is_i;
  logic        is_shift;
  logic        f7_zero;
  logic        f7_alt;
  logic        legal;

  // The instruction register only loads in IDLE, so every decoded field is
  // frozen from DECODE through WB regardless of activity on inst/start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (state == IDLE && start) begin
      ir <= inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (state == WB) begin
      retired <= retired + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? READ : IDLE;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    illegal = (state == DECODE) && !legal;
    ld_RR   = (state == READ);
    ld_F    = (state == EXEC);
    done    = (state == WB);
    rf_we   = (state == WB) && (rd_addr != 5'd0);
  end

  always_comb begin
    opcode   = ir[6:0];
    funct3   = ir[14:12];
    funct7   = ir[31:25];
    is_r     = (opcode == OPC_R);
    is_i     = (opcode == OPC_I);
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    f7_zero  = (funct7 == F7_ZERO);
    f7_alt   = (funct7 == F7_ALT);

    legal = 1'b0;
    if (is_r) begin
      legal = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (is_i) begin
      legal = !is_shift || f7_zero || (f7_alt && funct3 == 3'b101);
    end
  end

  always_comb begin
    rs1_addr  = ir[19:15];
    rs2_addr  = ir[24:20];
    rd_addr   = ir[11:7];
    rs2_imm_s = is_i;

    OP = {1'b0, funct3};
    if (funct3 == 3'b000 && is_r && f7_alt) begin
      OP = 4'b1000;
    end else if (funct3 == 3'b101 && f7_alt) begin
      OP = 4'b1101;
    end

    imm = '0;
    if (is_i) begin
      imm = is_shift ? {27'b0, ir[24:20]} : {{20{ir[31]}}, ir[31:20]};
    end
  end

endmodule
